// File: rtl/park_pkg.sv
// Shared package for the park exit decoder: FSM state type, default slot width
// and the slot-count derivation used by every module of the block.
package park_pkg;

    localparam int unsigned SLOT_W_DEF = 32'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        CHECK  = 2'd2,
        RESP   = 2'd3
    } park_state_e;

    function automatic int unsigned num_slots(input int unsigned slot_w);
        return 32'd1 << slot_w;
    endfunction

endpackage

// File: rtl/park_occupancy_map.sv
// Occupancy bitmap for the lot: entry set, exit clear, entry_err and the
// registered free-slot count.
module park_occupancy_map
    import park_pkg::*;
#(
    parameter  int unsigned SLOT_W    = SLOT_W_DEF,
    localparam int unsigned NUM_SLOTS = num_slots(SLOT_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_valid,
    input  logic [SLOT_W-1:0]    entry_slot,
    input  logic                 clear_en,
    input  logic [SLOT_W-1:0]    clear_slot,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [SLOT_W:0]      free_count,
    output logic                 entry_err,
    output logic                 entry_ok
);

    localparam logic [SLOT_W:0] FULL_COUNT = (SLOT_W + 1)'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [NUM_SLOTS-1:0] set_mask_s, clr_mask_s, avail_s;
    logic [SLOT_W:0]      free_q, free_d;
    logic                 err_q, err_d;

    function automatic logic [SLOT_W:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [SLOT_W:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            n = n + {{SLOT_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Next bitmap: a slot being freed this edge is treated as free for a
    // simultaneous entry, so the set wins and no entry_err is raised.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        err_d      = 1'b0;
        entry_ok   = 1'b0;
        if (clear_en) begin
            clr_mask_s[clear_slot] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        avail_s = occ_q & ~clr_mask_s;
        if (entry_valid) begin
            if (avail_s[entry_slot]) begin
                err_d = 1'b1;
            end else begin
                set_mask_s[entry_slot] = 1'b1;
                entry_ok               = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
        occ_d  = avail_s | set_mask_s;
        free_d = FULL_COUNT - popcount(occ_d);
    end

    // Bitmap, free count and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            free_q <= FULL_COUNT;
            err_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

    assign occupied   = occ_q;
    assign free_count = free_q;
    assign entry_err  = err_q;

endmodule

// File: rtl/park_exit_decoder.sv
// Parking-lot exit decoder: recovers slot = token ^ pattern, validates and frees
// it in the occupancy map. Optional exit lockout under macro PARK_FAIL_LOCK_EN.
module park_exit_decoder
    import park_pkg::*;
#(
    parameter  int unsigned SLOT_W    = SLOT_W_DEF,
    parameter  int unsigned MAX_FAILS = 32'd3,
    localparam int unsigned NUM_SLOTS = num_slots(SLOT_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exit_valid,
    output logic                 exit_ready,
    input  logic [SLOT_W-1:0]    token,
    input  logic [SLOT_W-1:0]    pattern,
    input  logic                 entry_valid,
    input  logic [SLOT_W-1:0]    entry_slot,
    output logic                 entry_err,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SLOT_W-1:0]    park_number,
    output logic                 res_ok,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [SLOT_W:0]      free_count,
    output logic                 locked
);

    park_state_e          state_q, state_d;
    logic [SLOT_W-1:0]    token_q, token_d, pattern_q, pattern_d;
    logic [SLOT_W-1:0]    slot_q, slot_d, park_number_q, park_number_d;
    logic                 res_valid_q, res_valid_d, res_ok_q, res_ok_d;
    logic                 exit_ready_q, exit_ready_d, locked_q, locked_d;
    logic                 clear_en_s, check_s, entry_ok_s;
    logic [NUM_SLOTS-1:0] occupied_s;

    park_occupancy_map #(.SLOT_W(SLOT_W)) u_map (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_valid (entry_valid),
        .entry_slot  (entry_slot),
        .clear_en    (clear_en_s),
        .clear_slot  (slot_q),
        .occupied    (occupied_s),
        .free_count  (free_count),
        .entry_err   (entry_err),
        .entry_ok    (entry_ok_s)
    );

    // Exit FSM next-state and result datapath.
    always_comb begin
        state_d       = state_q;
        token_d       = token_q;
        pattern_d     = pattern_q;
        slot_d        = slot_q;
        park_number_d = park_number_q;
        res_valid_d   = res_valid_q;
        res_ok_d      = res_ok_q;
        clear_en_s    = 1'b0;
        check_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_valid && exit_ready_q) begin
                    token_d   = token;
                    pattern_d = pattern;
                    state_d   = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                slot_d  = token_q ^ pattern_q;
                state_d = CHECK;
            end
            CHECK: begin
                res_ok_d      = occupied_s[slot_q];
                park_number_d = slot_q;
                clear_en_s    = occupied_s[slot_q];
                res_valid_d   = 1'b1;
                check_s       = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign exit_ready_d = (state_d == IDLE) && !locked_d;

`ifdef PARK_FAIL_LOCK_EN
    localparam int unsigned         FAIL_W     = $clog2(MAX_FAILS + 32'd1);
    localparam logic [FAIL_W-1:0]   FAIL_LIMIT = FAIL_W'(MAX_FAILS);

    logic [FAIL_W-1:0] fail_q, fail_d;

    // Saturating fail counter; a successful entry overrides a same-edge failure.
    always_comb begin
        fail_d = fail_q;
        if (entry_ok_s) begin
            fail_d = '0;
        end else if (check_s && !res_ok_d) begin
            if (fail_q != FAIL_LIMIT) begin
                fail_d = fail_q + 1'b1;
            end else begin
                fail_d = fail_q;
            end
        end else if (check_s) begin
            fail_d = '0;
        end else begin
            fail_d = fail_q;
        end
        locked_d = (fail_d >= FAIL_LIMIT);
    end

    // Fail counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end
`else
    // No lockout: constant 0, with the lock-related terms still referenced.
    assign locked_d = 1'b0 & check_s & entry_ok_s & (MAX_FAILS != 32'd0);
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            token_q       <= '0;
            pattern_q     <= '0;
            slot_q        <= '0;
            park_number_q <= '0;
            res_valid_q   <= 1'b0;
            res_ok_q      <= 1'b0;
            exit_ready_q  <= 1'b1;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            token_q       <= token_d;
            pattern_q     <= pattern_d;
            slot_q        <= slot_d;
            park_number_q <= park_number_d;
            res_valid_q   <= res_valid_d;
            res_ok_q      <= res_ok_d;
            exit_ready_q  <= exit_ready_d;
            locked_q      <= locked_d;
        end
    end

    assign exit_ready  = exit_ready_q;
    assign res_valid   = res_valid_q;
    assign park_number = park_number_q;
    assign res_ok      = res_ok_q;
    assign occupied    = occupied_s;
    assign locked      = locked_q;

endmodule
